// File: rtl/bp_input_conditioner.sv
// -----------------------------------------------------------------------------
// bp_input_conditioner
//
// Turns raw, active-high player inputs (keyboard or joystick) into the
// conditioned control bytes expected by the Blue Print core.
//   * Direction, fire and start bits are debounced against a 1 ms tick.
//   * Each coin input becomes fixed-width pulses separated by a minimum low
//     gap. Up to three extra coins are queued while a pulse is in progress.
//   * A wrapping 8-bit counter records every coin pulse issued.
//
// Ports
//   clk_49m      in   1  system clock
//   reset        in   1  asynchronous active-low reset
//   pause        in   1  1 = freeze all timers; outputs hold
//   raw_p1       in   8  {down,up,right,left,fire,x,start,coin}; bit 2 ignored
//   raw_p2       in   8  same layout for player 2
//   p1_controls  out  8  conditioned P1 byte; bit 2 always 0
//   p2_controls  out  8  conditioned P2 byte; bit 2 always 0
//   coin_count   out  8  coin pulses issued, both players, wraps
// -----------------------------------------------------------------------------
module bp_input_conditioner #(
   parameter int TICK_DIV      = 49152,
   parameter int DEBOUNCE_MS   = 4,
   parameter int COIN_PULSE_MS = 100,
   parameter int COIN_GAP_MS   = 50
) (
   input  logic       clk_49m,
   input  logic       reset,
   input  logic       pause,
   input  logic [7:0] raw_p1,
   input  logic [7:0] raw_p2,
   output logic [7:0] p1_controls,
   output logic [7:0] p2_controls,
   output logic [7:0] coin_count
);

   localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DB_W    = $clog2(DEBOUNCE_MS + 1);
   localparam int TMR_MAX = (COIN_PULSE_MS > COIN_GAP_MS) ? COIN_PULSE_MS : COIN_GAP_MS;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_MS - 1);
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(COIN_PULSE_MS - 1);
   localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(COIN_GAP_MS - 1);
   // Bit 2 is unused on the cabinet; masking it at the input keeps its
   // stable register at 0 permanently.
   localparam logic [7:0]       RAW_MASK   = 8'b1111_1011;

   typedef enum logic [1:0] {
      COIN_IDLE  = 2'd0,
      COIN_PULSE = 2'd1,
      COIN_GAP   = 2'd2
   } coin_state_t;

   logic [PRE_W-1:0] presc_r;
   logic             tick_s;

   logic [7:0]       raw_s       [2];
   logic [7:0]       stable_r    [2];
   logic [DB_W-1:0]  db_cnt_r    [2][8];

   logic [1:0]       coin_prev_r;
   logic [1:0]       coin_edge_s;

   coin_state_t      coin_state_r [2];
   logic [TMR_W-1:0] coin_tmr_r   [2];
   logic [1:0]       pend_r       [2];
   logic [1:0]       pend_eff_s   [2];
   logic [1:0]       coin_out_r;
   logic [1:0]       start_s;
   logic [1:0]       pulse_done_s;
   logic [1:0]       gap_done_s;

   logic [7:0]       coin_count_r;

   // The tick fires on the last prescaler count; pause suppresses it.
   assign tick_s = !pause && (presc_r == PRE_LAST);

   // Prescaler: free-running 0..TICK_DIV-1, held while paused.
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         presc_r <= '0;
      end else if (tick_s) begin
         presc_r <= '0;
      end else if (!pause) begin
         presc_r <= presc_r + PRE_W'(1);
      end else begin
         presc_r <= presc_r;
      end
   end

   // Mask the unused bit on both player inputs.
   always_comb begin
      raw_s[0] = raw_p1 & RAW_MASK;
      raw_s[1] = raw_p2 & RAW_MASK;
   end

   // Per-bit debounce: a change must survive DEBOUNCE_MS ticks to be accepted.
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 8; b++) begin
               stable_r[p][b] <= 1'b0;
               db_cnt_r[p][b] <= '0;
            end
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 8; b++) begin
               if (raw_s[p][b] == stable_r[p][b]) begin
                  db_cnt_r[p][b] <= '0;
               end else if (tick_s) begin
                  if (db_cnt_r[p][b] == DB_LAST) begin
                     stable_r[p][b] <= raw_s[p][b];
                     db_cnt_r[p][b] <= '0;
                  end else begin
                     db_cnt_r[p][b] <= db_cnt_r[p][b] + DB_W'(1);
                  end
               end
            end
         end
      end
   end

   // Previous debounced coin level, for rising-edge detection.
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         coin_prev_r <= 2'b00;
      end else begin
         coin_prev_r <= {stable_r[1][0], stable_r[0][0]};
      end
   end

   assign coin_edge_s = {stable_r[1][0], stable_r[0][0]} & ~coin_prev_r;

   // Coin FSM transition decode. pend_eff_s is the queue after counting any
   // edge this cycle, so an edge coinciding with the gap exit is queued and
   // then consumed in the same cycle.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         pulse_done_s[p] = 1'b0;
         gap_done_s[p]   = 1'b0;
         start_s[p]      = 1'b0;
         if (coin_edge_s[p] && (pend_r[p] != 2'd3)) begin
            pend_eff_s[p] = pend_r[p] + 2'd1;
         end else begin
            pend_eff_s[p] = pend_r[p];
         end
         case (coin_state_r[p])
            COIN_IDLE: begin
               start_s[p] = coin_edge_s[p];
            end
            COIN_PULSE: begin
               pulse_done_s[p] = tick_s && (coin_tmr_r[p] == PULSE_LAST);
            end
            COIN_GAP: begin
               gap_done_s[p] = tick_s && (coin_tmr_r[p] == GAP_LAST);
               start_s[p]    = gap_done_s[p] && (pend_eff_s[p] != 2'd0);
            end
            default: begin
               start_s[p] = 1'b0;
            end
         endcase
      end
   end

   // Coin pulse shaper, one independent FSM per player.
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         for (int p = 0; p < 2; p++) begin
            coin_state_r[p] <= COIN_IDLE;
            coin_tmr_r[p]   <= '0;
            pend_r[p]       <= 2'd0;
            coin_out_r[p]   <= 1'b0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            case (coin_state_r[p])
               COIN_IDLE: begin
                  if (start_s[p]) begin
                     coin_state_r[p] <= COIN_PULSE;
                     coin_tmr_r[p]   <= '0;
                     coin_out_r[p]   <= 1'b1;
                  end
               end
               COIN_PULSE: begin
                  pend_r[p] <= pend_eff_s[p];
                  if (pulse_done_s[p]) begin
                     coin_state_r[p] <= COIN_GAP;
                     coin_tmr_r[p]   <= '0;
                     coin_out_r[p]   <= 1'b0;
                  end else if (tick_s) begin
                     coin_tmr_r[p] <= coin_tmr_r[p] + TMR_W'(1);
                  end
               end
               COIN_GAP: begin
                  if (start_s[p]) begin
                     pend_r[p]       <= pend_eff_s[p] - 2'd1;
                     coin_state_r[p] <= COIN_PULSE;
                     coin_tmr_r[p]   <= '0;
                     coin_out_r[p]   <= 1'b1;
                  end else if (gap_done_s[p]) begin
                     pend_r[p]       <= pend_eff_s[p];
                     coin_state_r[p] <= COIN_IDLE;
                     coin_tmr_r[p]   <= '0;
                  end else begin
                     pend_r[p] <= pend_eff_s[p];
                     if (tick_s) begin
                        coin_tmr_r[p] <= coin_tmr_r[p] + TMR_W'(1);
                     end
                  end
               end
               default: begin
                  coin_state_r[p] <= COIN_IDLE;
                  coin_tmr_r[p]   <= '0;
                  pend_r[p]       <= 2'd0;
                  coin_out_r[p]   <= 1'b0;
               end
            endcase
         end
      end
   end

   // Coin counter: +1 per FSM entering PULSE, so simultaneous starts add 2.
   always_ff @(posedge clk_49m or negedge reset) begin
      if (!reset) begin
         coin_count_r <= 8'd0;
      end else begin
         coin_count_r <= coin_count_r + {7'd0, start_s[0]} + {7'd0, start_s[1]};
      end
   end

   assign p1_controls = {stable_r[0][7:3], 1'b0, stable_r[0][1], coin_out_r[0]};
   assign p2_controls = {stable_r[1][7:3], 1'b0, stable_r[1][1], coin_out_r[1]};
   assign coin_count  = coin_count_r;

endmodule

// File: tb/tb_bp_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_bp_input_conditioner
//
// Directed bench. Main instance: TICK_DIV=4, DEBOUNCE_MS=2, COIN_PULSE_MS=3,
// COIN_GAP_MS=2. A second instance with COIN_PULSE_MS=32 exercises the coin
// queue, since several debounced edges cannot fit inside a 3-tick pulse.
// -----------------------------------------------------------------------------
module tb_bp_input_conditioner;

   logic       clk_49m = 1'b0;
   logic       reset   = 1'b0;
   logic       pause   = 1'b0;
   logic [7:0] raw_p1  = 8'h00;
   logic [7:0] raw_p2  = 8'h00;
   logic [7:0] q_raw_p1 = 8'h00;
   logic [7:0] q_raw_p2 = 8'h00;
   logic [7:0] p1_controls, p2_controls, coin_count;
   logic [7:0] q_p1, q_p2, q_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk_49m = ~clk_49m;

   bp_input_conditioner #(
      .TICK_DIV(4), .DEBOUNCE_MS(2), .COIN_PULSE_MS(3), .COIN_GAP_MS(2)
   ) dut (
      .clk_49m(clk_49m), .reset(reset), .pause(pause),
      .raw_p1(raw_p1), .raw_p2(raw_p2),
      .p1_controls(p1_controls), .p2_controls(p2_controls), .coin_count(coin_count)
   );

   bp_input_conditioner #(
      .TICK_DIV(4), .DEBOUNCE_MS(2), .COIN_PULSE_MS(32), .COIN_GAP_MS(2)
   ) dut_q (
      .clk_49m(clk_49m), .reset(reset), .pause(pause),
      .raw_p1(q_raw_p1), .raw_p2(q_raw_p2),
      .p1_controls(q_p1), .p2_controls(q_p2), .coin_count(q_count)
   );

   task automatic check_val(input string tag, input int obs, input int expected);
      checks++;
      if (obs != expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expected);
      end
   endtask

   // Advance n rising edges and land 1 ns after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk_49m);
      #1;
   endtask

   // Hold reset for 3 cycles, check cleared outputs, release 1 ns after an edge.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      step(3);
      check_val({tag, "_p1"}, int'(p1_controls), 0);
      check_val({tag, "_p2"}, int'(p2_controls), 0);
      check_val({tag, "_cnt"}, int'(coin_count), 0);
      check_val({tag, "_qcnt"}, int'(q_count), 0);
      reset = 1'b1;
   endtask

   int n;
   int flag;
   int pre, post;
   int pulses, hi, lo, min_w, max_w, min_gap;
   logic prev_c;

   initial begin
      // ---------------- reset / idle ----------------
      raw_p1 = 8'hFF;
      raw_p2 = 8'hFF;
      do_reset("rst1");
      // Ticks land on the 4th and 8th edge after release.
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if ((p1_controls & 8'hFA) == 8'hFA) begin
            n = i;
            break;
         end
      end
      check_val("rel_latency", n, 8);
      check_val("rel_p1_bit2", int'(p1_controls[2]), 0);
      check_val("rel_p2_bits", int'(p2_controls & 8'hFE), 8'hFA);
      step(1);
      check_val("rel_coin_p1", int'(p1_controls[0]), 1);
      check_val("rel_coin_p2", int'(p2_controls[0]), 1);
      check_val("rel_cnt", int'(coin_count), 2);
      raw_p1 = 8'h00;
      raw_p2 = 8'h00;
      step(60);
      check_val("rel_idle_p1", int'(p1_controls), 0);
      check_val("rel_idle_cnt", int'(coin_count), 2);

      // ---------------- glitch rejection ----------------
      do_reset("rst2");
      step(2);
      raw_p1[6] = 1'b1;
      flag = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (p1_controls[6]) flag = 1;
      end
      raw_p1[6] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (p1_controls[6]) flag = 1;
      end
      check_val("glitch_rej", flag, 0);
      raw_p1[6] = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (p1_controls[6]) begin
            n = i;
            break;
         end
      end
      check_val("hold_latency", n, 8);
      check_val("hold_byte", int'(p1_controls), 8'h40);
      raw_p1 = 8'h00;
      step(20);
      check_val("hold_release", int'(p1_controls), 0);

      // ---------------- single coin ----------------
      do_reset("rst3");
      raw_p1[0] = 1'b1;
      pulses = 0; hi = 0; prev_c = 1'b0;
      for (int i = 0; i < 160; i++) begin
         step(1);
         if (p1_controls[0]) begin
            if (!prev_c) pulses++;
            hi++;
         end
         prev_c = p1_controls[0];
      end
      check_val("single_pulses", pulses, 1);
      check_val("single_width", hi, 11);
      check_val("single_cnt", int'(coin_count), 1);
      check_val("single_end", int'(p1_controls[0]), 0);
      raw_p1 = 8'h00;
      step(40);

      // ---------------- queue saturation (long-pulse instance) ----------------
      do_reset("rst4");
      pulses = 0; hi = 0; lo = 0; min_w = 9999; max_w = 0; min_gap = 9999;
      prev_c = 1'b0;
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               q_raw_p1[0] = 1'b1;
               step(12);
               q_raw_p1[0] = 1'b0;
               step(12);
            end
         end
         begin
            for (int i = 0; i < 800; i++) begin
               step(1);
               if (q_p1[0]) begin
                  if (!prev_c) begin
                     pulses++;
                     if (pulses > 1 && lo < min_gap) min_gap = lo;
                     hi = 0;
                  end
                  hi++;
               end else begin
                  if (prev_c) begin
                     if (hi < min_w) min_w = hi;
                     if (hi > max_w) max_w = hi;
                     lo = 0;
                  end
                  lo++;
               end
               prev_c = q_p1[0];
            end
         end
      join
      check_val("sat_pulses", pulses, 4);
      check_val("sat_cnt", int'(q_count), 4);
      check_val("sat_min_width", int'(min_w >= 125), 1);
      check_val("sat_max_width", int'(max_w <= 128), 1);
      check_val("sat_min_gap", int'(min_gap >= 5), 1);
      check_val("sat_end", int'(q_p1[0]), 0);

      // ---------------- simultaneous coins ----------------
      do_reset("rst5");
      raw_p1[0] = 1'b1;
      raw_p2[0] = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (p1_controls[0] || p2_controls[0]) begin
            n = i;
            break;
         end
      end
      check_val("sim_latency", n, 9);
      check_val("sim_p1", int'(p1_controls[0]), 1);
      check_val("sim_p2", int'(p2_controls[0]), 1);
      check_val("sim_cnt", int'(coin_count), 2);
      raw_p1 = 8'h00;
      raw_p2 = 8'h00;
      step(40);

      // ---------------- pause mid-pulse ----------------
      do_reset("rst6");
      raw_p1[0] = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (p1_controls[0]) begin
            n = i;
            break;
         end
      end
      check_val("pause_start", n, 9);
      pre = 1;
      for (int i = 0; i < 2; i++) begin
         step(1);
         if (p1_controls[0]) pre++;
      end
      pause = 1'b1;
      flag = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (!p1_controls[0]) flag = 1;
      end
      check_val("pause_hold", flag, 0);
      pause = 1'b0;
      post = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (p1_controls[0]) post++;
         else break;
      end
      check_val("pause_width", pre + post, 11);
      check_val("pause_cnt", int'(coin_count), 1);

      // ---------------- reset mid-pulse ----------------
      raw_p1[0] = 1'b0;
      step(20);
      raw_p1[0] = 1'b1;
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         step(1);
         if (p1_controls[0]) begin
            n = i;
            break;
         end
      end
      check_val("mid_pulse_seen", int'(n > 0), 1);
      check_val("mid_pulse_cnt", int'(coin_count), 2);
      reset = 1'b0;
      #1;
      check_val("async_rst_coin", int'(p1_controls[0]), 0);
      check_val("async_rst_cnt", int'(coin_count), 0);
      step(2);
      raw_p1 = 8'h00;
      reset = 1'b1;
      step(20);
      check_val("post_rst_idle", int'(p1_controls), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
